// File: rtl/matriz_unaria_seq_pkg.sv
// matriz_unaria_seq_pkg: shared op/size encodings, FSM states and active element count
package matriz_unaria_seq_pkg;

    typedef enum logic [1:0] {OP_NEG = 2'b00, OP_ABS = 2'b01, OP_COPY = 2'b10, OP_CLR = 2'b11} op_e;
    typedef enum logic [1:0] {SZ_2X2 = 2'b00, SZ_3X3 = 2'b01, SZ_4X4 = 2'b10, SZ_5X5 = 2'b11} size_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int active_count(input logic [1:0] sz, input int max_dim);
        int d;
        d = int'(sz) + 2;
        d = d > max_dim ? max_dim : d;
        return d * d;
    endfunction

endpackage

// File: rtl/matriz_unaria_seq_if.sv
// matriz_unaria_seq_if: start/busy/done handshake plus packed operand and result buses
interface matriz_unaria_seq_if #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5
);
    localparam int W = MAX_DIM * MAX_DIM * DATA_W;

    logic         start;
    logic [1:0]   op_mode;
    logic [1:0]   matrix_size;
    logic [W-1:0] matrix_A;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [W-1:0] m_result;

    modport master (output start, op_mode, matrix_size, matrix_A, input busy, done, overflow, m_result);
    modport slave  (input start, op_mode, matrix_size, matrix_A, output busy, done, overflow, m_result);

endinterface

// File: rtl/matriz_unaria_seq_elem.sv
// matriz_unaria_seq_elem: combinational single-element unary op with saturation and overflow flag
module matriz_unaria_seq_elem
    import matriz_unaria_seq_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SATURATE = 1
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic              ovf
);
    localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic neg;

    always_comb begin
        neg = op == OP_NEG || (op == OP_ABS && x[DATA_W-1]);
        ovf = neg && x == MIN;
        y   = op == OP_CLR ? '0 : !neg ? x : ovf ? (SATURATE != 0 ? ~MIN : MIN) : -x;
    end

endmodule

// File: rtl/matriz_unaria_seq.sv
// matriz_unaria_seq: sequential element-wise unary op on a packed square matrix, LANES elements per cycle
module matriz_unaria_seq
    import matriz_unaria_seq_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_DIM  = 5,
    parameter int LANES    = 5,
    parameter int SATURATE = 1
) (
    input logic clk,
    input logic rst_n,
    matriz_unaria_seq_if.slave bus
);
    localparam int NE = MAX_DIM * MAX_DIM;
    localparam int IW = $clog2(NE + 2 * LANES + 1);
    localparam logic [IW-1:0] LW = IW'(LANES);

    state_e                   state;
    op_e                      op_q;
    logic [NE*DATA_W-1:0]     a_q;
    logic [NE*DATA_W-1:0]     res;
    logic [IW-1:0]            n_q;
    logic [IW-1:0]            idx;
    logic                     busy;
    logic                     done;
    logic                     ovf;
    logic [LANES*DATA_W-1:0]  win;
    logic [DATA_W-1:0]        y_l [LANES];
    logic [LANES-1:0]         ov_l;
    logic [LANES-1:0]         vld;

    // lane j always sees element idx+j of the latched operand
    assign win = (LANES*DATA_W)'(a_q >> (32'(idx) * DATA_W));

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign vld[j] = (idx + IW'(j)) < n_q;
        matriz_unaria_seq_elem #(.DATA_W(DATA_W), .SATURATE(SATURATE)) u_elem (
            .op (op_q),
            .x  (win[j*DATA_W +: DATA_W]),
            .y  (y_l[j]),
            .ovf(ov_l[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= OP_NEG;
            a_q   <= '0;
            res   <= '0;
            n_q   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_q   <= bus.matrix_A;
                    op_q  <= op_e'(bus.op_mode);
                    n_q   <= IW'(active_count(bus.matrix_size, MAX_DIM));
                    res   <= '0;
                    ovf   <= 1'b0;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    for (int j = 0; j < LANES; j++)
                        if (vld[j]) res[(int'(idx) + j) * DATA_W +: DATA_W] <= y_l[j];
                    ovf <= ovf | (|(ov_l & vld));
                    idx <= idx + LW;
                    if (idx + LW >= n_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.overflow = ovf;
    assign bus.m_result = res;

endmodule

// File: tb/tb_matriz_unaria_seq.sv
// tb_matriz_unaria_seq: table-driven and randomized checks of two builds (defaults, and LANES=1 wrap)
module tb_matriz_unaria_seq;
    localparam int W = 200;

    typedef struct {
        logic [W-1:0] a;
        logic [1:0]   op;
        logic [1:0]   sz;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic         o0;
        logic         o1;
        int           r0;
        int           r1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    matriz_unaria_seq_if b0();
    matriz_unaria_seq_if b1();

    matriz_unaria_seq dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    matriz_unaria_seq #(.LANES(1), .SATURATE(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic drive(input logic s, input logic [W-1:0] a, input logic [1:0] op, input logic [1:0] sz);
        b0.start = s; b0.matrix_A = a; b0.op_mode = op; b0.matrix_size = sz;
        b1.start = s; b1.matrix_A = a; b1.op_mode = op; b1.matrix_size = sz;
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [1:0] op, input logic [1:0] sz,
                                  input bit sat, output logic [W-1:0] r, output logic o);
        int n;
        n = (int'(sz) + 2) * (int'(sz) + 2);
        r = '0;
        o = 1'b0;
        for (int e = 0; e < n; e++) begin
            int x;
            int v;
            x = $signed(a[e*8 +: 8]);
            v = op == 2'd0 ? -x : op == 2'd1 ? (x < 0 ? -x : x) : op == 2'd2 ? x : 0;
            if (v > 127) begin
                o = 1'b1;
                v = sat ? 127 : -128;
            end
            r[e*8 +: 8] = v[7:0];
        end
    endfunction

    function automatic int run_cycles(input logic [1:0] sz, input int lanes);
        int n;
        n = (int'(sz) + 2) * (int'(sz) + 2);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [1:0] op, input logic [1:0] sz);
        vec_t v;
        v.a = a; v.op = op; v.sz = sz;
        model(a, op, sz, 1'b1, v.e0, v.o0);
        model(a, op, sz, 1'b0, v.e1, v.o1);
        v.r0 = run_cycles(sz, 5);
        v.r1 = run_cycles(sz, 1);
        return v;
    endfunction

    // edge count c is measured from the edge after which start was raised
    task automatic do_op(input vec_t v, input bit meddle,
                         output logic [W-1:0] r0, output logic [W-1:0] r1, output logic o0, output logic o1,
                         output int d0, output int d1, output int w0, output int w1);
        d0 = 0; d1 = 0; w0 = 0; w1 = 0; r0 = '0; r1 = '0; o0 = 1'b0; o1 = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, v.a, v.op, v.sz);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (meddle && c == 1) drive(1'b1, ~v.a, 2'b11, v.sz);
            else begin b0.start = 1'b0; b1.start = 1'b0; end
            if (b0.done) begin
                w0++;
                if (d0 == 0) begin d0 = c; r0 = b0.m_result; o0 = b0.overflow; end
            end
            if (b1.done) begin
                w1++;
                if (d1 == 0) begin d1 = c; r1 = b1.m_result; o1 = b1.overflow; end
            end
            if (d0 != 0 && d1 != 0 && c > (d0 > d1 ? d0 : d1) + 1) break;
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v, input bit meddle);
        logic [W-1:0] r0, r1;
        logic o0, o1;
        int d0, d1, w0, w1;
        do_op(v, meddle, r0, r1, o0, o1, d0, d1, w0, w1);
        chk({nm, " res0"}, r0, v.e0);
        chk({nm, " res1"}, r1, v.e1);
        chk({nm, " ovf0"}, o0, v.o0);
        chk({nm, " ovf1"}, o1, v.o1);
        chk({nm, " lat0"}, d0, v.r0 + 1);
        chk({nm, " lat1"}, d1, v.r1 + 1);
        chk({nm, " pulse0"}, w0, 1);
        chk({nm, " pulse1"}, w1, 1);
        chk({nm, " hold0"}, b0.m_result, v.e0);
    endtask

    vec_t tbl [3];

    initial begin
        logic [W-1:0] a;
        logic seen;
        int d0, d1, i0, i1, s0, s1;

        tbl[0].a = {25{8'h55}}; tbl[0].a[31:0] = 32'h007F_FE01;
        tbl[0].op = 2'b00; tbl[0].sz = 2'b00;
        tbl[0].e0 = '0; tbl[0].e0[31:0] = 32'h0081_02FF; tbl[0].e1 = tbl[0].e0;
        tbl[0].o0 = 1'b0; tbl[0].o1 = 1'b0; tbl[0].r0 = 1; tbl[0].r1 = 4;

        tbl[1].a = {25{8'hFD}}; tbl[1].a[63:56] = 8'h80;
        tbl[1].op = 2'b01; tbl[1].sz = 2'b11;
        tbl[1].e0 = {25{8'h03}}; tbl[1].e0[63:56] = 8'h7F;
        tbl[1].e1 = {25{8'h03}}; tbl[1].e1[63:56] = 8'h80;
        tbl[1].o0 = 1'b1; tbl[1].o1 = 1'b1; tbl[1].r0 = 5; tbl[1].r1 = 25;

        tbl[2].a = {25{8'h80}}; tbl[2].op = 2'b00; tbl[2].sz = 2'b10;
        tbl[2].e0 = '0; tbl[2].e0[127:0] = {16{8'h7F}};
        tbl[2].e1 = '0; tbl[2].e1[127:0] = {16{8'h80}};
        tbl[2].o0 = 1'b1; tbl[2].o1 = 1'b1; tbl[2].r0 = 4; tbl[2].r1 = 16;

        drive(1'b0, '0, 2'b00, 2'b00);
        @(posedge clk); #1;
        chk("rst busy0", b0.busy, 0);
        chk("rst done0", b0.done, 0);
        chk("rst ovf0", b0.overflow, 0);
        chk("rst res0", b0.m_result, 0);
        chk("rst busy1", b1.busy, 0);
        chk("rst res1", b1.m_result, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 3; k++) run_vec($sformatf("tbl%0d", k), tbl[k], 1'b0);

        for (int k = 0; k < 24; k++) begin
            for (int e = 0; e < 25; e++) a[e*8 +: 8] = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
            run_vec($sformatf("rnd%0d", k), mk(a, 2'($urandom), 2'($urandom)), 1'b0);
        end

        for (int e = 0; e < 25; e++) a[e*8 +: 8] = 8'($urandom);
        run_vec("restart", mk(a, 2'b10, 2'b01), 1'b1);

        for (int e = 0; e < 25; e++) a[e*8 +: 8] = 8'($urandom);
        a[7:0] = 8'h80;
        @(posedge clk); #1;
        drive(1'b1, a, 2'b00, 2'b10);
        @(posedge clk); #1;
        b0.start = 1'b0; b1.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy0", b0.busy, 0);
        chk("abort done0", b0.done, 0);
        chk("abort ovf0", b0.overflow, 0);
        chk("abort res0", b0.m_result, 0);
        chk("abort busy1", b1.busy, 0);
        chk("abort ovf1", b1.overflow, 0);
        chk("abort res1", b1.m_result, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            seen = seen | b0.done | b1.done | b0.busy | b1.busy;
        end
        chk("abort quiet", seen, 0);
        run_vec("post_rst", mk(a, 2'b00, 2'b10), 1'b0);

        a = {25{8'h7F}};
        @(posedge clk); #1;
        drive(1'b1, a, 2'b11, 2'b11);
        d0 = 0; d1 = 0; i0 = 0; i1 = 0; s0 = 0; s1 = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            if (d0 == 0 && b0.done) d0 = c;
            else if (d0 != 0 && i0 == 0 && !b0.busy) i0 = c;
            else if (i0 != 0 && s0 == 0 && b0.busy) s0 = c;
            if (d1 == 0 && b1.done) d1 = c;
            else if (d1 != 0 && i1 == 0 && !b1.busy) i1 = c;
            else if (i1 != 0 && s1 == 0 && b1.busy) s1 = c;
            if (d0 == 0 || d1 == 0) begin
                chk("clr run0", b0.m_result, 0);
            end
            if (s0 != 0 && s1 != 0) break;
        end
        b0.start = 1'b0; b1.start = 1'b0;
        chk("held lat0", d0, 6);
        chk("held lat1", d1, 26);
        chk("held idle0", i0, d0 + 1);
        chk("held idle1", i1, d1 + 1);
        chk("held again0", s0, d0 + 2);
        chk("held again1", s1, d1 + 2);
        for (int c = 0; c < 60 && (b0.busy || b1.busy); c++) begin
            @(posedge clk); #1;
        end
        chk("held end busy", {b0.busy, b1.busy}, 0);
        chk("held clr0", b0.m_result, 0);
        chk("held clr1", b1.m_result, 0);
        chk("held ovf", {b0.overflow, b1.overflow}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
